// File: rtl/seg_pkg.sv
// Shared glyph table, FSM states and anode helpers for the seven-segment scan monitor.
// Glyphs are active-low {a,b,c,d,e,f,g}, matching the display driver's encoder.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_IDLE = 4'hF;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Number of asserted (low) anode lines.
    function automatic logic [2:0] count_low(input logic [3:0] an);
        return {2'b00, ~an[0]} + {2'b00, ~an[1]} + {2'b00, ~an[2]} + {2'b00, ~an[3]};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the display driver's hex encoder.
// hit=0 for any pattern that is neither a hex glyph nor the blank glyph.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       hit,
    output logic       is_blank
);

    always_comb begin
        nib      = 4'h0;
        hit      = 1'b1;
        is_blank = 1'b0;
        case (seg)
            SEG_0:     nib = 4'h0;
            SEG_1:     nib = 4'h1;
            SEG_2:     nib = 4'h2;
            SEG_3:     nib = 4'h3;
            SEG_4:     nib = 4'h4;
            SEG_5:     nib = 4'h5;
            SEG_6:     nib = 4'h6;
            SEG_7:     nib = 4'h7;
            SEG_8:     nib = 4'h8;
            SEG_9:     nib = 4'h9;
            SEG_A:     nib = 4'hA;
            SEG_B:     nib = 4'hB;
            SEG_C:     nib = 4'hC;
            SEG_D:     nib = 4'hD;
            SEG_E:     nib = 4'hE;
            SEG_F:     nib = 4'hF;
            SEG_BLANK: is_blank = 1'b1;
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed AN/CX seven-segment bus, captures each digit once stable and
// publishes a 16-bit value per complete four-digit frame; err flags bad anodes/glyphs/timeouts.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  AN,
    input  logic [7:0]  CX,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        err
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [3:0]       s_an_q, s_an_d;
    logic [7:0]       s_cx_q, s_cx_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    state_t           state_q, state_d;
    logic [3:0]       flag_q, flag_d;
    logic [3:0][3:0]  slot_nib_q, slot_nib_d;
    logic [3:0]       slot_dp_q, slot_dp_d;
    logic [3:0]       slot_blank_q, slot_blank_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       blank_q, blank_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [3:0]    dec_nib;
    logic          dec_hit;
    logic          dec_blank;
    logic          same;
    logic          reach;
    logic [2:0]    n_low;
    logic          legal;
    logic          illegal;
    logic [1:0]    idx;
    logic          capture;
    logic          bad;
    logic [3:0]    cap_mask;
    logic [TW-1:0] tmo_inc;

    seg7_decode u_dec (
        .seg      (s_cx_q[7:1]),
        .nib      (dec_nib),
        .hit      (dec_hit),
        .is_blank (dec_blank)
    );

    // The incoming sample is compared against the registered one, so the counter
    // tracks how long {s_an,s_cx} has held; stab_q==0 only right after reset.
    always_comb begin
        s_an_d  = AN;
        s_cx_d  = CX;
        same    = (AN == s_an_q) && (CX == s_cx_q);
        stab_d  = SW'(1);
        if (same && stab_q != '0) begin
            stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
        end
        reach   = same && (stab_q == STAB_PRE);

        n_low   = count_low(s_an_q);
        legal   = (n_low == 3'd1);
        illegal = (n_low >= 3'd2);
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!s_an_q[i]) idx = 2'(i);
        end

        capture  = reach && legal && dec_hit;
        bad      = reach && (illegal || (legal && !dec_hit));
        cap_mask = capture ? (4'b0001 << idx) : 4'b0000;
    end

    always_comb begin
        slot_nib_d   = slot_nib_q;
        slot_dp_d    = slot_dp_q;
        slot_blank_d = slot_blank_q;
        if (capture) begin
            slot_nib_d[idx]   = dec_nib;
            slot_dp_d[idx]    = ~s_cx_q[0];
            slot_blank_d[idx] = dec_blank;
        end
    end

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q | cap_mask;
        tmo_d   = tmo_q;
        tmo_inc = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + 1'b1;
        value_d = value_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        valid_d = 1'b0;
        err_d   = bad;
        case (state_q)
            WAIT: begin
                if (capture) state_d = COLLECT;
            end
            COLLECT: begin
                if (&flag_q) begin
                    state_d = EMIT;
                end else begin
                    tmo_d = tmo_inc;
                    if (!capture && tmo_inc == TMO_MAX) begin
                        flag_d  = 4'b0000;
                        err_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            EMIT: begin
                for (int i = 0; i < 4; i++) begin
                    value_d[4*i +: 4] = slot_nib_q[i];
                end
                dp_d    = slot_dp_q;
                blank_d = slot_blank_q;
                valid_d = 1'b1;
                // A digit captured on the emit edge opens the next frame.
                flag_d  = cap_mask;
                state_d = capture ? COLLECT : WAIT;
            end
            default: state_d = WAIT;
        endcase
        if (capture) tmo_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_an_q       <= '0;
            s_cx_q       <= '0;
            stab_q       <= '0;
            tmo_q        <= '0;
            state_q      <= WAIT;
            flag_q       <= '0;
            slot_nib_q   <= '0;
            slot_dp_q    <= '0;
            slot_blank_q <= '0;
            value_q      <= '0;
            dp_q         <= '0;
            blank_q      <= 4'hF;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            s_an_q       <= s_an_d;
            s_cx_q       <= s_cx_d;
            stab_q       <= stab_d;
            tmo_q        <= tmo_d;
            state_q      <= state_d;
            flag_q       <= flag_d;
            slot_nib_q   <= slot_nib_d;
            slot_dp_q    <= slot_dp_d;
            slot_blank_q <= slot_blank_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign value = value_q;
    assign dp    = dp_q;
    assign blank = blank_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
